// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result handshake bundle (in_valid/in_ready op+operands, out_valid/out_ready result+illegal_op)
interface alu_exec_if #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic             use_imm;
  logic [IMM_W-1:0] immediate;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_result;
  logic             illegal_op;
  modport master (
    output in_valid, alu_op, use_imm, immediate, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_result, illegal_op
  );
  modport slave (
    input  in_valid, alu_op, use_imm, immediate, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_result, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute ALU with iterative MUL; ports clk, reset (sync active-high), bus (alu_exec_if.slave)
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 12,
  parameter bit MUL_EN = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  alu_exec_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ILL_PAT = XLEN'(32'hDEADBEEF);
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state;
  logic [XLEN-1:0] a, b, res, res_r, mcand, mplier, acc, acc_next;
  logic [SW-1:0] sh;
  logic [SW:0] count;
  logic ov, ill_r, ill, is_mul, accept;
  assign a = bus.rs1_data;
  assign b = bus.use_imm ? XLEN'($signed(bus.immediate)) : bus.rs2_data;
  assign sh = b[SW-1:0];
  assign ill = (bus.alu_op >= 4'd12) || (bus.alu_op == 4'd11 && !MUL_EN);
  assign is_mul = (bus.alu_op == 4'd11) && MUL_EN;
  assign bus.in_ready = (state == IDLE) && (!ov || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ov;
  assign bus.alu_result = res_r;
  assign bus.illegal_op = ill_r;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    res = ILL_PAT;
    case (bus.alu_op)
      4'd1:  res = a + b;
      4'd2:  res = a - b;
      4'd3:  res = a & b;
      4'd4:  res = a | b;
      4'd5:  res = a ^ b;
      4'd6:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd7:  res = {{(XLEN-1){1'b0}}, a < b};
      4'd8:  res = a << sh;
      4'd9:  res = a >> sh;
      4'd10: res = XLEN'($signed(a) >>> sh);
      default: res = ILL_PAT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ov    <= 1'b0;
      ill_r <= 1'b0;
      res_r <= '0;
      count <= '0;
    end else begin
      if (ov && bus.out_ready) ov <= 1'b0;
      if (state == IDLE) begin
        if (accept && bus.alu_op != 4'd0) begin
          if (is_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= (SW+1)'(XLEN);
            state  <= MUL_BUSY;
          end else begin
            res_r <= res;
            ill_r <= ill;
            ov    <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - (SW+1)'(1);
        if (count == (SW+1)'(1)) begin
          res_r <= acc_next;
          ill_r <= 1'b0;
          ov    <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the RISCAT core, sitting between the register-file read stage and writeback. It takes one operation per handshake and returns one result per handshake over a valid/ready interface. It supports the RV32I integer register-register and register-immediate ops in a single cycle, plus an optional iterative multiply that holds the unit busy for XLEN cycles. An illegal-op flag marks unsupported commands.

## Interface

- XLEN, 32: datapath width; power of two, ≥ 8.
- IMM_W, 12: immediate width; sign-extended to XLEN.
- MUL_EN, 1: 1 = MUL implemented; 0 = MUL treated as illegal.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request presented.
- in_ready  out  1  unit can accept this cycle.
- alu_op  in  4  command: 0 NONE, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL; 12-15 illegal.
- use_imm  in  1  operand B = sext(immediate) instead of rs2_data.
- immediate  in  IMM_W  immediate operand.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  operand B when use_imm = 0.
- out_valid  out  1  result held on alu_result.
- out_ready  in  1  consumer takes result.
- alu_result  out  XLEN  result.
- illegal_op  out  1  qualifies out_valid; result is the illegal pattern.

## Operation

- States: IDLE, MUL_BUSY.
- Acceptance: an edge where in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A result and a new request can complete on the same edge.
- Operands: A = rs1_data; B = use_imm ? sext(immediate) : rs2_data. Operands are sampled only at acceptance.
- Arithmetic: ADD and SUB are modulo 2^XLEN, with no flags.
  - SLT and SLTU give 1 or 0, zero-extended. SLT is signed; SLTU is unsigned.
  - Shifts use B[log2(XLEN)-1:0]; upper bits of B are ignored. SRA replicates A[XLEN-1].
- NONE: accepted, produces no result. out_valid is not set and state is unchanged.
- Single-cycle ops: at acceptance, alu_result ← result, out_valid ← 1, illegal_op ← 0.
- Illegal op (12-15, or 11 with MUL_EN = 0): at acceptance, alu_result ← 32'hDEADBEEF (truncated or zero-extended to XLEN), out_valid ← 1, illegal_op ← 1.
- MUL (MUL_EN = 1): at acceptance, load multiplicand = A, multiplier = B, accumulator = 0, count = XLEN; go to MUL_BUSY.
  - Each MUL_BUSY edge: if multiplier[0], add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement count.
  - On the edge where count goes 1→0: alu_result ← low XLEN bits of the accumulator including that step, out_valid ← 1, state ← IDLE.
  - The result is identical for signed and unsigned operands (low half).
- Output hold: while out_valid && !out_ready, alu_result and illegal_op stay stable. On out_ready && out_valid, out_valid clears unless a new result loads on the same edge.
- Reset (any state, including mid-MUL): state ← IDLE, out_valid ← 0, illegal_op ← 0, alu_result ← 0, count ← 0. An in-flight MUL is discarded without producing output.

## Timing

- Single-cycle ops and illegal ops: acceptance at edge N; out_valid high after edge N (latency 1).
- MUL: acceptance at edge N; out_valid high after edge N+XLEN. in_ready is low from after edge N until state returns to IDLE and the output is free.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle; in_ready stays high.
- in_ready depends combinationally on out_ready. No other combinational input→output path exists.
- Reset has priority over every other event on the same edge.

## Test plan

- Reset, then ADD rs1 = 5, use_imm = 1, imm = 12'hFFF → one cycle later out_valid = 1, alu_result = 4, illegal_op = 0; outputs were 0 during reset.
- SUB 0 - 1 → FFFFFFFF; SLT FFFFFFFF vs 1 → 1; SLTU same operands → 0; SRA 80000000 by 4 → F8000000; SLL 1 by 33 (rs2) → 2.
- MUL 12345 × 678 (XLEN = 32) → in_ready low for the busy window; out_valid exactly 32 cycles after acceptance; alu_result = 8369910. Repeat with FFFFFFFF × FFFFFFFF → 1.
- out_ready held low for 5 cycles after an XOR result → alu_result stable and in_ready low; the new op is accepted on the same edge the result is taken.
- alu_op = 13, and MUL with MUL_EN = 0 → out_valid = 1, illegal_op = 1, alu_result = DEADBEEF. NONE → no out_valid.
- Assert reset at cycle 10 of a MUL → after the reset edge: out_valid = 0, in_ready = 1; no stale result appears afterwards.
